// File: rtl/div_clk_monitor_pkg.sv
// div_clk_monitor_pkg
//   Shared definitions for the divided-clock monitor:
//   - state_t      : monitor FSM encoding (IDLE, ARM, MEAS)
//   - DEF_*        : default parameter values for div_clk_monitor
//   - in_window()  : inclusive range check used for period/high-time windows
package div_clk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PER_MIN     = 28;
  localparam int DEF_PER_MAX     = 32;
  localparam int DEF_HI_MIN      = 13;
  localparam int DEF_HI_MAX      = 17;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_LOCK_CNT    = 4;

  function automatic logic in_window(input logic [31:0] v,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/div_clk_sync_edge.sv
// div_clk_sync_edge
//   Brings the asynchronous divided clock into the clk domain and produces
//   single-cycle rise/fall pulses. SYNC_STAGES synchroniser flops are followed
//   by one delay flop; the pulses are registered, so an edge on div_clk shows
//   up as a pulse SYNC_STAGES+1 clk cycles later.
// Ports
//   clk      in  reference clock
//   rst_n    in  asynchronous active-low reset
//   div_clk  in  divided clock under test (asynchronous)
//   level    out synchronised level, aligned with the rise/fall pulses
//   rise     out 1-cycle pulse on a rising edge of div_clk
//   fall     out 1-cycle pulse on a falling edge of div_clk
module div_clk_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_clk,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;

  assign s = sync_q[SYNC_STAGES-1];

  // s_d is one cycle behind s, which is exactly the cycle in which the
  // registered pulses are visible, so s_d is the level that matches them.
  assign level = s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
      s_d    <= s;
      rise   <= s & ~s_d;
      fall   <= ~s & s_d;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
//   Checks the divided clock produced by the odd-ratio divider. The divided
//   clock is sampled as asynchronous data in the clk domain; the period and
//   high time are measured in clk cycles on every rising edge and checked
//   against windows. Results are reported per period, errors are sticky and
//   a lock flag indicates LOCK_CNT consecutive good periods.
// Optional feature
//   DIV_CLK_MONITOR_MINMAX_EN : adds per_min_o/per_max_o, the smallest and
//   largest captured periods since reset or the last clr_err.
// Ports
//   clk         in   reference clock
//   rst_n       in   asynchronous active-low reset
//   en          in   monitor enable
//   clr_err     in   clears the sticky error flags
//   div_clk_i   in   divided clock under test, asynchronous to clk
//   period_cnt  out  last captured period
//   high_cnt    out  last captured high time
//   meas_valid  out  1-cycle pulse with each new period_cnt/high_cnt
//   err_period  out  sticky: period outside [PER_MIN,PER_MAX]
//   err_duty    out  sticky: high time outside [HI_MIN,HI_MAX]
//   err_stuck   out  sticky: TIMEOUT cycles without a rising edge
//   lock        out  LOCK_CNT consecutive good periods seen
//   per_min_o   out  (optional) smallest captured period
//   per_max_o   out  (optional) largest captured period
//   fsm_state   out  current monitor FSM state (debug)
// Handshake: meas_valid is a plain pulse with no back-pressure; period_cnt,
//   high_cnt, the error flags and lock are all valid in the meas_valid cycle.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PER_MIN     = DEF_PER_MIN,
  parameter int PER_MAX     = DEF_PER_MAX,
  parameter int HI_MIN      = DEF_HI_MIN,
  parameter int HI_MAX      = DEF_HI_MAX,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int LOCK_CNT    = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  input  logic             div_clk_i,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stuck,
  output logic             lock,
`ifdef DIV_CLK_MONITOR_MINMAX_EN
  output logic [CNT_W-1:0] per_min_o,
  output logic [CNT_W-1:0] per_max_o,
`endif
  output state_t           fsm_state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_V    = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    LOCK_M1   = GW'(LOCK_CNT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic lvl;
  logic rise;
  logic fall;

  div_clk_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_clk(div_clk_i),
    .level  (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  logic run_clear;  // run counters forced to 0
  logic arm_rise;   // first rise after arming: start measuring, no result
  logic take_meas;  // rise in MEAS: capture and check a full period
  logic timeout;    // TIMEOUT cycles without a rise
  logic in_meas;

  logic [CNT_W-1:0] per_run;
  logic [CNT_W-1:0] hi_run;
  logic [CNT_W-1:0] hi_cap;
  logic             fall_seen;
  logic [GW-1:0]    good_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM:  if (rise)    state_d = ST_MEAS;
        ST_MEAS: if (timeout) state_d = ST_ARM;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run_clear = 1'b0;
    arm_rise  = 1'b0;
    take_meas = 1'b0;
    timeout   = 1'b0;
    in_meas   = 1'b0;
    if (!en) begin
      run_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: run_clear = 1'b1;
        ST_ARM: begin
          arm_rise = rise;
          timeout  = !rise && (per_run == TIMEOUT_V);
        end
        ST_MEAS: begin
          in_meas   = 1'b1;
          take_meas = rise;
          timeout   = !rise && (per_run == TIMEOUT_V);
        end
        default: run_clear = 1'b1;
      endcase
    end
  end

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------
  // Run counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_run   <= '0;
      hi_run    <= '0;
      hi_cap    <= '0;
      fall_seen <= 1'b0;
    end else if (run_clear) begin
      per_run   <= '0;
      hi_run    <= '0;
      hi_cap    <= '0;
      fall_seen <= 1'b0;
    end else if (arm_rise || take_meas) begin
      // The rise cycle itself is the first cycle of the new period and of
      // its high phase.
      per_run   <= CNT_W'(1);
      hi_run    <= CNT_W'(1);
      fall_seen <= 1'b0;
    end else if (timeout) begin
      per_run   <= '0;
      hi_run    <= '0;
      fall_seen <= 1'b0;
    end else begin
      per_run <= sat_inc(per_run);
      if (in_meas && lvl) hi_run <= sat_inc(hi_run);
      if (in_meas && fall) begin
        hi_cap    <= hi_run;
        fall_seen <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture, window checks, sticky errors and lock
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cap_hi;
  logic             per_ok;
  logic             hi_ok;

  // Without a fall since the previous rise the whole period counts as high
  // time, and that is always a duty error.
  assign cap_hi = fall_seen ? hi_cap : per_run;
  assign per_ok = in_window(32'(per_run), 32'(PER_MIN), 32'(PER_MAX));
  assign hi_ok  = fall_seen && in_window(32'(hi_cap), 32'(HI_MIN), 32'(HI_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      err_period <= 1'b0;
      err_duty   <= 1'b0;
      err_stuck  <= 1'b0;
      lock       <= 1'b0;
      good_cnt   <= '0;
    end else begin
      meas_valid <= take_meas;
      if (take_meas) begin
        period_cnt <= per_run;
        high_cnt   <= cap_hi;
      end
      // A new error wins over a simultaneous clear.
      err_period <= (err_period & ~clr_err) | (take_meas & ~per_ok);
      err_duty   <= (err_duty   & ~clr_err) | (take_meas & ~hi_ok);
      err_stuck  <= (err_stuck  & ~clr_err) | timeout;

      if (!en || timeout) begin
        good_cnt <= '0;
        lock     <= 1'b0;
      end else if (take_meas) begin
        if (per_ok && hi_ok) begin
          if (good_cnt < LOCK_V) good_cnt <= good_cnt + GW'(1);
          lock <= (good_cnt >= LOCK_M1);
        end else begin
          good_cnt <= '0;
          lock     <= 1'b0;
        end
      end
    end
  end

`ifdef DIV_CLK_MONITOR_MINMAX_EN
  // per_min_o starts at all-ones so the first captured period replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_min_o <= '1;
      per_max_o <= '0;
    end else if (clr_err && take_meas) begin
      per_min_o <= per_run;
      per_max_o <= per_run;
    end else if (clr_err) begin
      per_min_o <= '1;
      per_max_o <= '0;
    end else if (take_meas) begin
      if (per_run < per_min_o) per_min_o <= per_run;
      if (per_run > per_max_o) per_max_o <= per_run;
    end
  end
`endif

endmodule
